// File: rtl/hilo_divider_seq.sv
// hilo_divider_seq: multi-cycle restoring divider with HI/LO result registers
// for the CPU EX stage. It produces one quotient bit per clock, then writes
// LO = quotient and HI = remainder. MFHI/MFLO reads are served from IDLE, and
// a stall is raised while a divide is in flight.
//
// Build option: define DIVIDER_SIGNED_EN to accept DIV (two's-complement).
// In that build a FIX state is added for sign correction, and DIVU passes
// through FIX as well so that both divides have the same latency. Without the
// macro, DIV is ignored like any unrecognised function code.
module hilo_divider_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             div_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             stall,
    output logic [WIDTH-1:0] dataOut,
    output logic             HiLo_signal,
    output logic             alu_out_sel
);

    localparam logic [5:0] FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
`ifdef DIVIDER_SIGNED_EN
    localparam logic [5:0] FN_DIV  = 6'b011010;
`endif
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] quo_q;      // dividend shifts out of the top, quotient bits enter at the bottom
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic             div0_q;
    logic [WIDTH-1:0] dataout_q;
    logic             hilo_q;
    logic             alu_sel_q;

    logic             is_divu;
    logic             is_div;
    logic             is_mfhi;
    logic             is_mflo;
    logic             div_req;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

`ifdef DIVIDER_SIGNED_EN
    logic             a_neg;
    logic             b_neg;
    logic             a_neg_q;    // remainder takes the dividend's sign
    logic             q_neg_q;    // quotient is negative when the operand signs differ
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
`endif

    // Decode of the function code presented with start
    always_comb begin
        is_divu = (Funct == FN_DIVU);
        is_mfhi = (Funct == FN_MFHI);
        is_mflo = (Funct == FN_MFLO);
`ifdef DIVIDER_SIGNED_EN
        is_div  = (Funct == FN_DIV);
`else
        is_div  = 1'b0;
`endif
        div_req = is_divu | is_div;
    end

    // Operand magnitudes; DIVU keeps the raw values
    always_comb begin
        a_abs = dataA;
        b_abs = dataB;
`ifdef DIVIDER_SIGNED_EN
        a_neg = is_div & dataA[WIDTH-1];
        b_neg = is_div & dataB[WIDTH-1];
        if (a_neg) a_abs = -dataA;
        if (b_neg) b_abs = -dataB;
`endif
    end

    // One restoring step. The trial difference is always below the divisor
    // when it fits, so the low WIDTH bits of the subtraction are exact.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvs_q});
        rem_step = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], fits};
    end

`ifdef DIVIDER_SIGNED_EN
    // Sign correction applied to the unsigned result in the FIX state
    always_comb begin
        quo_fix = q_neg_q ? -quo_q : quo_q;
        rem_fix = a_neg_q ? -rem_q : rem_q;
    end
`endif

    // A read must wait while the FSM is not idle, including the DONE cycle
    assign stall = start & (is_mfhi | is_mflo) & busy_q;

    assign busy        = busy_q;
    assign done        = done_q;
    assign div0        = div0_q;
    assign dataOut     = dataout_q;
    assign HiLo_signal = hilo_q;
    assign alu_out_sel = alu_sel_q;

    // Divider FSM, HI/LO registers and the read port
    always_ff @(posedge div_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            dataout_q <= '0;
            hilo_q    <= 1'b0;
            alu_sel_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            a_neg_q   <= 1'b0;
            q_neg_q   <= 1'b0;
`endif
        end else begin
            alu_sel_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && div_req) begin
                        busy_q <= 1'b1;
                        if (dataB == '0) begin
                            // Divide by zero completes immediately with a fixed result
                            hi_q    <= dataA;
                            lo_q    <= '1;
                            div0_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            quo_q   <= a_abs;
                            dvs_q   <= b_abs;
                            rem_q   <= '0;
                            count_q <= CNT_START;
`ifdef DIVIDER_SIGNED_EN
                            a_neg_q <= a_neg;
                            q_neg_q <= a_neg ^ b_neg;
`endif
                            state_q <= S_CALC;
                        end
                    end else if (start && (is_mfhi || is_mflo)) begin
                        dataout_q <= is_mflo ? lo_q : hi_q;
                        hilo_q    <= is_mflo;
                        alu_sel_q <= 1'b1;
                    end
                end
                S_CALC: begin
                    quo_q   <= quo_step;
                    rem_q   <= rem_step;
                    count_q <= count_q - CNT_ONE;
                    if (count_q == CNT_ONE) begin
`ifdef DIVIDER_SIGNED_EN
                        state_q <= S_FIX;
`else
                        lo_q    <= quo_step;
                        hi_q    <= rem_step;
                        div0_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`endif
                    end
                end
`ifdef DIVIDER_SIGNED_EN
                S_FIX: begin
                    lo_q    <= quo_fix;
                    hi_q    <= rem_fix;
                    div0_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
`endif
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_divider_seq.sv
// Directed testbench for hilo_divider_seq (WIDTH=32). It follows the build
// option DIVIDER_SIGNED_EN for the expected latency and the DIV vectors.
module tb_hilo_divider_seq;

    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_OTHER = 6'b100000;
`ifdef DIVIDER_SIGNED_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  Funct;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic        div0;
    logic        stall;
    logic [31:0] dataOut;
    logic        HiLo_signal;
    logic        alu_out_sel;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_read = '0;

    always #5 clk = ~clk;

    hilo_divider_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .div_clk     (clk),
        .rst         (rst),
        .start       (start),
        .Funct       (Funct),
        .dataA       (dataA),
        .dataB       (dataB),
        .busy        (busy),
        .done        (done),
        .div0        (div0),
        .stall       (stall),
        .dataOut     (dataOut),
        .HiLo_signal (HiLo_signal),
        .alu_out_sel (alu_out_sel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, got, exp);
    endtask

    // Issue MFHI/MFLO from IDLE and check the registered read one edge later
    task automatic mf_read(input string tag, input logic [5:0] fn, input logic [31:0] exp);
        start = 1'b1;
        Funct = fn;
        #1;
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        check(tag, dataOut, exp);
        check({tag, "_sel"}, {31'd0, alu_out_sel}, 32'd1);
        check({tag, "_hilo"}, {31'd0, HiLo_signal}, (fn == F_MFLO) ? 32'd1 : 32'd0);
        tick();
        check({tag, "_selpulse"}, {31'd0, alu_out_sel}, 32'd0);
        last_read = exp;
    endtask

    // Start a divide and measure the cycle in which done rises (start edge = cycle 0)
    task automatic do_div(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic exp_div0);
        int cyc;
        start = 1'b1;
        Funct = fn;
        dataA = a;
        dataB = b;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_div0"}, {31'd0, div0}, {31'd0, exp_div0});
        check({tag, "_busyd"}, {31'd0, busy}, 32'd1);
        tick();
        check({tag, "_busy0"}, {31'd0, busy}, 32'd0);
        check({tag, "_done0"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        Funct = F_OTHER;
        dataA = '0;
        dataB = '0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_div0", {31'd0, div0}, 32'd0);
        check("rst_dout", dataOut, 32'd0);
        check("rst_hilo", {31'd0, HiLo_signal}, 32'd0);
        check("rst_sel", {31'd0, alu_out_sel}, 32'd0);
        rst = 1'b0;
        tick();
        mf_read("rst_mflo", F_MFLO, 32'd0);

        // Basic unsigned divides
        do_div("d100_7", F_DIVU, 32'd100, 32'd7, LAT, 1'b0);
        mf_read("d100_7_lo", F_MFLO, 32'd14);
        mf_read("d100_7_hi", F_MFHI, 32'd2);
        do_div("dmax_1", F_DIVU, 32'hFFFF_FFFF, 32'd1, LAT, 1'b0);
        mf_read("dmax_1_lo", F_MFLO, 32'hFFFF_FFFF);
        mf_read("dmax_1_hi", F_MFHI, 32'd0);
        do_div("d5_9", F_DIVU, 32'd5, 32'd9, LAT, 1'b0);
        mf_read("d5_9_lo", F_MFLO, 32'd0);
        mf_read("d5_9_hi", F_MFHI, 32'd5);

        // Divide by zero, then a normal divide clears div0
        do_div("dz", F_DIVU, 32'd1234, 32'd0, 1, 1'b1);
        mf_read("dz_hi", F_MFHI, 32'd1234);
        mf_read("dz_lo", F_MFLO, 32'hFFFF_FFFF);
        do_div("d9_3", F_DIVU, 32'd9, 32'd3, LAT, 1'b0);
        mf_read("d9_3_lo", F_MFLO, 32'd3);

        // Reads and divides issued while busy
        start = 1'b1;
        Funct = F_DIVU;
        dataA = 32'd200;
        dataB = 32'd10;
        tick();
        start = 1'b0;
        cyc = 1;
        repeat (9) begin
            tick();
            cyc++;
        end
        start = 1'b1;
        Funct = F_DIVU;
        dataA = 32'd8;
        dataB = 32'd2;
        #1;
        check("busy_divu_stall", {31'd0, stall}, 32'd0);
        tick();
        cyc++;
        Funct = F_MFLO;
        #1;
        check("busy_mflo_stall", {31'd0, stall}, 32'd1);
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("busy_lat", cyc, LAT);
        check("done_stall", {31'd0, stall}, 32'd1);
        check("done_dout_hold", dataOut, last_read);
        check("done_sel", {31'd0, alu_out_sel}, 32'd0);
        tick();
        check("idle_nostall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        check("reissue_lo", dataOut, 32'd20);
        check("reissue_sel", {31'd0, alu_out_sel}, 32'd1);
        last_read = 32'd20;
        tick();
        mf_read("d200_hi", F_MFHI, 32'd0);

        // Reset in the middle of a divide
        start = 1'b1;
        Funct = F_DIVU;
        dataA = 32'd1000;
        dataB = 32'd3;
        tick();
        start = 1'b0;
        repeat (14) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        tick();
        mf_read("abort_lo", F_MFLO, 32'd0);
        do_div("d10_4", F_DIVU, 32'd10, 32'd4, LAT, 1'b0);
        mf_read("d10_4_hi", F_MFHI, 32'd2);

        // Unrecognised function codes leave everything alone
        start = 1'b1;
        Funct = F_OTHER;
        tick();
        start = 1'b0;
        check("other_busy", {31'd0, busy}, 32'd0);
        check("other_sel", {31'd0, alu_out_sel}, 32'd0);
        check("other_dout", dataOut, last_read);

`ifdef DIVIDER_SIGNED_EN
        do_div("sm7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, LAT, 1'b0);
        mf_read("sm7_2_lo", F_MFLO, 32'hFFFF_FFFD);
        mf_read("sm7_2_hi", F_MFHI, 32'hFFFF_FFFF);
        do_div("s7_m2", F_DIV, 32'd7, 32'hFFFF_FFFE, LAT, 1'b0);
        mf_read("s7_m2_lo", F_MFLO, 32'hFFFF_FFFD);
        mf_read("s7_m2_hi", F_MFHI, 32'd1);
        do_div("smin_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, LAT, 1'b0);
        mf_read("smin_m1_lo", F_MFLO, 32'h8000_0000);
        mf_read("smin_m1_hi", F_MFHI, 32'd0);
`else
        start = 1'b1;
        Funct = F_DIV;
        dataA = 32'd50;
        dataB = 32'd5;
        tick();
        start = 1'b0;
        check("div_ign_busy", {31'd0, busy}, 32'd0);
        check("div_ign_sel", {31'd0, alu_out_sel}, 32'd0);
        tick();
        mf_read("div_ign_lo", F_MFLO, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
